// File: rtl/operand_quad_loader_pkg.sv
// Shared types and constants for the operand quad loader.
package operand_quad_loader_pkg;

  // FILL: accepting words; HOLD: complete quad presented and settling.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } loader_state_t;

  localparam int unsigned NUM_OPERANDS = 4;
  localparam int unsigned IDX_W        = 2;
  localparam int unsigned CNT_W        = 8;

  // True when the word index points at the final operand (D).
  function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(NUM_OPERANDS - 1);
  endfunction

endpackage

// File: rtl/operand_quad_loader_hold_timer.sv
// Loadable down-counter used to time a settling window. It stops at zero and
// flags expiry while the count reads 1, so the caller acts on the last cycle.
module hold_timer
  import operand_quad_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] r_count;

  // Count register: reset/clear win, then load, then decrement toward zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Expiry decode.
  always_comb begin
    expire = (r_count == CNT_W'(1));
  end

endmodule

// File: rtl/operand_quad_loader.sv
// Assembles four consecutive handshake words into the operands A..D of a
// downstream combinational block, holds them for HOLD_CYCLES, then captures
// the returned out_sig into res_bit with a one-cycle res_valid pulse.
module operand_quad_loader
  import operand_quad_loader_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic             quad_valid,
  input  logic             out_sig,
  output logic             res_bit,
  output logic             res_valid,
  output logic [7:0]       quad_cnt
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 1..255");
  end

  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYCLES);

  loader_state_t    r_state;
  loader_state_t    w_state_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_d;

  logic             r_res_bit;
  logic             r_res_valid;
  logic [7:0]       r_quad_cnt;

  logic             w_accept;
  logic             w_last_word;
  logic             w_expire;
  logic             w_sample;

  // Handshake and event decode; flush outranks both accept and sample.
  always_comb begin
    w_accept    = in_valid && (r_state == FILL) && !flush;
    w_last_word = w_accept && is_last_idx(r_idx);
    w_sample    = (r_state == HOLD) && w_expire && !flush;
  end

  hold_timer u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .load     (w_last_word),
    .load_val (HoldLoad),
    .expire   (w_expire)
  );

  // Next-state and word index logic.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    if (flush) begin
      w_state_next = FILL;
      w_idx_next   = '0;
    end else begin
      unique case (r_state)
        FILL: begin
          if (w_accept) begin
            if (is_last_idx(r_idx)) begin
              w_idx_next   = '0;
              w_state_next = HOLD;
            end else begin
              w_idx_next = r_idx + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (w_expire) begin
            w_state_next = FILL;
          end
        end
        default: w_state_next = FILL;
      endcase
    end
  end

  // State and index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Operand registers: each accept writes only the slot selected by the index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      r_d <= '0;
    end else if (w_accept) begin
      unique case (r_idx)
        2'd0: r_a <= in_data;
        2'd1: r_b <= in_data;
        2'd2: r_c <= in_data;
        2'd3: r_d <= in_data;
        default: ;
      endcase
    end
  end

  // Result capture, valid pulse and completed-quad counter (wraps naturally).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_bit   <= 1'b0;
      r_res_valid <= 1'b0;
      r_quad_cnt  <= '0;
    end else begin
      r_res_valid <= w_sample;
      if (w_sample) begin
        r_res_bit  <= out_sig;
        r_quad_cnt <= r_quad_cnt + 8'd1;
      end
    end
  end

  // Output drive; handshake flags decode straight from the registered state.
  always_comb begin
    in_ready   = (r_state == FILL);
    quad_valid = (r_state == HOLD);
    A          = r_a;
    B          = r_b;
    C          = r_c;
    D          = r_d;
    res_bit    = r_res_bit;
    res_valid  = r_res_valid;
    quad_cnt   = r_quad_cnt;
  end

endmodule
